// File: rtl/wbu_retire_buf_pkg.sv
// Shared types and constants for the writeback/retire stage: load funct3
// codes, the resolved retire-buffer entry and the writeback value select.
package wbu_pkg;

  localparam int WBU_XLEN      = 32;
  localparam int WBU_RADDR_W   = 5;
  localparam int WBU_CSR_WEN_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Entries hold only final values; nothing is re-resolved at the head.
  typedef struct packed {
    logic [WBU_XLEN-1:0]      pc;
    logic [WBU_XLEN-1:0]      value;
    logic [WBU_XLEN-1:0]      csrd;
    logic [WBU_RADDR_W-1:0]   rd;
    logic                     rf_wen;
    logic [WBU_CSR_WEN_W-1:0] csr_wen;
  } wbu_entry_t;

  // Link/CSR-old value beats load data, which beats the ALU result.
  function automatic logic [WBU_XLEN-1:0] wb_select(
    input logic                use_rd_value,
    input logic                is_load,
    input logic [WBU_XLEN-1:0] rd_value,
    input logic [WBU_XLEN-1:0] load_value,
    input logic [WBU_XLEN-1:0] ex_result
  );
    logic [WBU_XLEN-1:0] sel;
    if (use_rd_value) begin
      sel = rd_value;
    end else if (is_load) begin
      sel = load_value;
    end else begin
      sel = ex_result;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wbu_retire_buf_if.sv
// MEM-to-retire and retire-to-commit handshake bundle; slave is the stage,
// master is whatever drives it (MEM on the input side, commit on the output).
interface wbu_retire_buf_if #(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int CSR_WEN_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_ex_result;
  logic [XLEN-1:0]      in_mem_rdata;
  logic [1:0]           in_mem_addr_lo;
  logic [2:0]           in_mem_funct3;
  logic                 in_mem_ren;
  logic [XLEN-1:0]      in_rd_value;
  logic [RADDR_W-1:0]   in_rd;
  logic                 in_rf_wen;
  logic                 in_jump;
  logic [CSR_WEN_W-1:0] in_csr_wen;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic                 out_rf_wen;
  logic [RADDR_W-1:0]   out_rd;
  logic [XLEN-1:0]      out_rd_value;
  logic [CSR_WEN_W-1:0] out_csr_wen;
  logic [XLEN-1:0]      out_csrd;

  modport master (
    output in_valid, in_pc, in_ex_result, in_mem_rdata, in_mem_addr_lo,
           in_mem_funct3, in_mem_ren, in_rd_value, in_rd, in_rf_wen,
           in_jump, in_csr_wen, out_ready,
    input  in_ready, out_valid, out_pc, out_rf_wen, out_rd, out_rd_value,
           out_csr_wen, out_csrd
  );

  modport slave (
    input  in_valid, in_pc, in_ex_result, in_mem_rdata, in_mem_addr_lo,
           in_mem_funct3, in_mem_ren, in_rd_value, in_rd, in_rf_wen,
           in_jump, in_csr_wen, out_ready,
    output in_ready, out_valid, out_pc, out_rf_wen, out_rd, out_rd_value,
           out_csr_wen, out_csrd
  );
endinterface

// File: rtl/wbu_retire_buf_load_align.sv
// Combinational RV32I load extraction: picks the byte/halfword addressed by
// addr_lo from the aligned word and sign- or zero-extends it.
module wbu_load_align
  import wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select; halfwords use only addr_lo[1].
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by funct3; unknown codes pass the raw word.
  always_comb begin
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wbu_retire_buf.sv
// Writeback/retire stage: resolves the writeback value at enqueue and holds up
// to DEPTH entries in a circular FIFO. Define WBU_TRACE_EN for retire trace
// outputs and a 64-bit instret counter.
module wbu_retire_buf
  import wbu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int CSR_WEN_W = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  wbu_retire_buf_if.slave      bus,
  output logic [3:0]           occupancy
`ifdef WBU_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [XLEN-1:0]      trace_pc,
  output logic [RADDR_W-1:0]   trace_rd,
  output logic                 trace_wen,
  output logic [XLEN-1:0]      trace_value,
  output logic [63:0]          instret
`endif
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);

  wbu_entry_t       mem_q [DEPTH];
  wbu_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]       count_q, count_d;

  logic [XLEN-1:0]  load_s;
  wbu_entry_t       new_s;
  wbu_entry_t       head_s;
  logic             enq_s;
  logic             deq_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  wbu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (bus.in_mem_rdata),
    .addr_lo (bus.in_mem_addr_lo),
    .funct3  (bus.in_mem_funct3),
    .result  (load_s)
  );

  // Build the resolved entry for the incoming instruction.
  always_comb begin
    new_s         = '0;
    new_s.pc      = bus.in_pc;
    new_s.value   = wb_select(bus.in_jump || (|bus.in_csr_wen), bus.in_mem_ren,
                              bus.in_rd_value, load_s, bus.in_ex_result);
    new_s.csrd    = bus.in_ex_result;
    new_s.rd      = bus.in_rd;
    new_s.rf_wen  = bus.in_rf_wen && (bus.in_rd != '0);
    new_s.csr_wen = bus.in_csr_wen;
  end

  // Handshake and head outputs; write enables are masked by out_valid so a
  // flushed buffer with stale storage never commits.
  always_comb begin
    head_s           = mem_q[rd_ptr_q];
    bus.out_valid    = (count_q != 4'd0);
    bus.in_ready     = (count_q < DEPTH_C) || bus.out_ready;
    enq_s            = bus.in_valid && bus.in_ready;
    deq_s            = bus.out_valid && bus.out_ready;
    bus.out_pc       = head_s.pc;
    bus.out_rd       = head_s.rd;
    bus.out_rd_value = head_s.value;
    bus.out_csrd     = head_s.csrd;
    bus.out_rf_wen   = head_s.rf_wen && bus.out_valid;
    bus.out_csr_wen  = head_s.csr_wen & {CSR_WEN_W{bus.out_valid}};
    occupancy        = count_q;
  end

  // FIFO next state; flush wins over any same-cycle enqueue or dequeue.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (enq_s) begin
        mem_d[wr_ptr_q] = new_s;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state and storage registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef WBU_TRACE_EN
  logic               retire_s;
  logic               trace_valid_q, trace_valid_d;
  logic [XLEN-1:0]    trace_pc_q, trace_pc_d;
  logic [RADDR_W-1:0] trace_rd_q, trace_rd_d;
  logic               trace_wen_q, trace_wen_d;
  logic [XLEN-1:0]    trace_value_q, trace_value_d;
  logic [63:0]        instret_q, instret_d;

  // A dequeue swallowed by flush is not a retirement.
  always_comb begin
    retire_s      = deq_s && !flush;
    trace_valid_d = retire_s;
    if (retire_s) begin
      trace_pc_d    = head_s.pc;
      trace_rd_d    = head_s.rd;
      trace_wen_d   = head_s.rf_wen;
      trace_value_d = head_s.value;
      instret_d     = instret_q + 64'd1;
    end else begin
      trace_pc_d    = trace_pc_q;
      trace_rd_d    = trace_rd_q;
      trace_wen_d   = trace_wen_q;
      trace_value_d = trace_value_q;
      instret_d     = instret_q;
    end
  end

  // Trace and instret registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_rd_q    <= '0;
      trace_wen_q   <= 1'b0;
      trace_value_q <= '0;
      instret_q     <= 64'd0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_rd_q    <= trace_rd_d;
      trace_wen_q   <= trace_wen_d;
      trace_value_q <= trace_value_d;
      instret_q     <= instret_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_rd    = trace_rd_q;
  assign trace_wen   = trace_wen_q;
  assign trace_value = trace_value_q;
  assign instret     = instret_q;
`endif

endmodule

// File: tb/tb_wbu_retire_buf.sv
// Bench for wbu_retire_buf: directed scenarios plus randomized traffic checked
// against a queue-based model of the retire buffer.
module tb_wbu_retire_buf;

  localparam int XLEN      = 32;
  localparam int RADDR_W   = 5;
  localparam int CSR_WEN_W = 4;
  localparam int DEPTH     = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [3:0] occupancy;
`ifdef WBU_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic        trace_wen;
  logic [31:0] trace_value;
  logic [63:0] instret;
  logic [31:0] trace_q[$];
`endif

  wbu_retire_buf_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CSR_WEN_W(CSR_WEN_W)) bus();

  wbu_retire_buf #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CSR_WEN_W(CSR_WEN_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus.slave),
    .occupancy (occupancy)
`ifdef WBU_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_wen   (trace_wen),
    .trace_value (trace_value),
    .instret     (instret)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] value;
    logic [31:0] csrd;
    logic [4:0]  rd;
    logic        rf_wen;
    logic [3:0]  csr_wen;
  } exp_t;

  exp_t        mq[$];
  exp_t        pend;
  logic [31:0] ret_q[$];
  logic        exp_enq;
  logic        exp_deq;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic exp_t ref_entry();
    exp_t e;
    e.pc = bus.in_pc;
    if (bus.in_jump || (bus.in_csr_wen != 4'd0)) e.value = bus.in_rd_value;
    else if (bus.in_mem_ren) e.value = ref_load(bus.in_mem_rdata, bus.in_mem_addr_lo, bus.in_mem_funct3);
    else e.value = bus.in_ex_result;
    e.csrd    = bus.in_ex_result;
    e.rd      = bus.in_rd;
    e.rf_wen  = bus.in_rf_wen && (bus.in_rd != 5'd0);
    e.csr_wen = bus.in_csr_wen;
    return e;
  endfunction

  task automatic sample_check();
    logic exp_ready;
    @(negedge clock);
    exp_ready = (mq.size() < DEPTH) || bus.out_ready;
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    check_eq("occupancy", 64'(occupancy), 64'(mq.size()));
    check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
      check_eq("out_rd", 64'(bus.out_rd), 64'(mq[0].rd));
      check_eq("out_rd_value", 64'(bus.out_rd_value), 64'(mq[0].value));
      check_eq("out_rf_wen", 64'(bus.out_rf_wen), 64'(mq[0].rf_wen));
      check_eq("out_csr_wen", 64'(bus.out_csr_wen), 64'(mq[0].csr_wen));
      check_eq("out_csrd", 64'(bus.out_csrd), 64'(mq[0].csrd));
    end else begin
      check_eq("idle_rf_wen", 64'(bus.out_rf_wen), 64'd0);
      check_eq("idle_csr_wen", 64'(bus.out_csr_wen), 64'd0);
    end
    exp_enq = bus.in_valid && exp_ready;
    exp_deq = (mq.size() != 0) && bus.out_ready;
    pend    = ref_entry();
  endtask

  task automatic commit();
    @(posedge clock);
    if (flush) begin
      mq.delete();
    end else begin
      if (exp_deq) begin
        ret_q.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (exp_enq) mq.push_back(pend);
    end
    #1;
  endtask

  task automatic cyc();
    sample_check();
    commit();
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] ex, input logic [31:0] rdata,
                        input logic [1:0] lo, input logic [2:0] f3, input logic ren,
                        input logic [31:0] rdv, input logic [4:0] rd, input logic rfw,
                        input logic jump, input logic [3:0] csr);
    bus.in_pc = pc;            bus.in_ex_result = ex;    bus.in_mem_rdata = rdata;
    bus.in_mem_addr_lo = lo;   bus.in_mem_funct3 = f3;   bus.in_mem_ren = ren;
    bus.in_rd_value = rdv;     bus.in_rd = rd;           bus.in_rf_wen = rfw;
    bus.in_jump = jump;        bus.in_csr_wen = csr;
  endtask

`ifdef WBU_TRACE_EN
  always @(negedge clock) begin
    if (reset_n && trace_valid) trace_q.push_back(trace_pc);
  end
`endif

  logic [2:0]  lf3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  llo [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
  logic [31:0] lexp[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02};
  string       lnm [4] = '{"load_lb", "load_lbu", "load_lh", "load_lhu"};

  initial begin
    logic last_acc;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    set_in(32'd0, 32'd0, 32'd0, 2'd0, 3'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0);
    #12;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_pc", 64'(bus.out_pc), 64'd0);
    check_eq("rst_out_rd_value", 64'(bus.out_rd_value), 64'd0);
    check_eq("rst_out_csrd", 64'(bus.out_csrd), 64'd0);
    check_eq("rst_out_rf_wen", 64'(bus.out_rf_wen), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock) #1;

    // load extraction vectors
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = 1'b1;
      set_in(32'h100 + 32'(i * 4), 32'h1111, 32'h80F17F02, llo[i], lf3[i], 1'b1,
             32'h2222, 5'd5, 1'b1, 1'b0, 4'd0);
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      sample_check();
      check_eq(lnm[i], 64'(bus.out_rd_value), 64'(lexp[i]));
      commit();
    end

    // backpressure at DEPTH=2
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    set_in(32'h300, 32'hA, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd1, 1'b1, 1'b0, 4'd0);
    cyc();
    set_in(32'h304, 32'hB, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd2, 1'b1, 1'b0, 4'd0);
    cyc();
    set_in(32'h308, 32'hC, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, 4'd0);
    sample_check();
    check_eq("bp_full_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp_full_occ", 64'(occupancy), 64'd2);
    commit();
    bus.out_ready = 1'b1;
    sample_check();
    check_eq("bp_accept_ready", 64'(bus.in_ready), 64'd1);
    commit();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    sample_check();
    check_eq("bp_occ_kept", 64'(occupancy), 64'd2);
    check_eq("bp_head", 64'(bus.out_pc), 64'h304);
    commit();
    bus.out_ready = 1'b1;
    repeat (3) cyc();

    // value priority and write-enable gating
    bus.in_valid = 1'b1;
    set_in(32'h400, 32'h999, 32'h12345678, 2'd0, 3'd0, 1'b1, 32'h104, 5'd1, 1'b1, 1'b1, 4'd0);
    cyc();
    bus.in_valid = 1'b0;
    sample_check();
    check_eq("prio_jump", 64'(bus.out_rd_value), 64'h104);
    commit();
    bus.in_valid = 1'b1;
    set_in(32'h404, 32'h77, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 4'd0);
    cyc();
    bus.in_valid = 1'b0;
    sample_check();
    check_eq("x0_gate", 64'(bus.out_rf_wen), 64'd0);
    commit();
    bus.in_valid = 1'b1;
    set_in(32'h408, 32'hCAFEF00D, 32'd0, 2'd0, 3'd2, 1'b0, 32'h55, 5'd7, 1'b1, 1'b0, 4'b0010);
    cyc();
    bus.in_valid = 1'b0;
    sample_check();
    check_eq("csrd", 64'(bus.out_csrd), 64'hCAFEF00D);
    check_eq("csr_wen", 64'(bus.out_csr_wen), 64'h2);
    check_eq("csr_rd_value", 64'(bus.out_rd_value), 64'h55);
    commit();

    // flush colliding with enqueue and dequeue on a full buffer
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    set_in(32'h500, 32'h1, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, 4'd0);
    cyc();
    set_in(32'h504, 32'h2, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, 4'd0);
    cyc();
    set_in(32'h5555, 32'h3, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0, 4'd0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sample_check();
    check_eq("flush_occ", 64'(occupancy), 64'd0);
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    commit();
    repeat (3) cyc();

    // asynchronous reset with two entries queued
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    set_in(32'h600, 32'h1, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd9, 1'b1, 1'b0, 4'd0);
    cyc();
    set_in(32'h604, 32'h2, 32'd0, 2'd0, 3'd2, 1'b0, 32'd0, 5'd9, 1'b1, 1'b0, 4'd0);
    cyc();
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_occupancy", 64'(occupancy), 64'd0);
    check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
    mq.delete();
    ret_q.delete();
`ifdef WBU_TRACE_EN
    trace_q.delete();
`endif
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock) #1;

    // randomized traffic; a stalled input is held until accepted
    last_acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        set_in($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1), $urandom,
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
      if (((i / 50) % 2) == 1) bus.out_ready = ($urandom_range(0, 9) < 2);
      else bus.out_ready = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 24) == 0);
      sample_check();
      last_acc = exp_enq;
      commit();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();

`ifdef WBU_TRACE_EN
    check_eq("instret", instret, 64'(ret_q.size()));
    check_eq("trace_count", 64'(trace_q.size()), 64'(ret_q.size()));
    for (int k = 0; k < ret_q.size() && k < trace_q.size(); k++) begin
      check_eq("trace_pc_order", 64'(trace_q[k]), 64'(ret_q[k]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
